// File: rtl/seq_display_pkg.sv
// Shared constants for the scrolling sequence display: segment codes, digit ROM, direction encoding.
// Pure constants, no timing or flow control.
package seq_display_pkg;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  // Active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [3:0] SEQ_ROM [16] = '{
    4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6,
    4'd5, 4'd3, 4'd5, 4'd8, 4'd9, 4'd7, 4'd9, 4'd3
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Nibble to active-low seven-segment decoder; purely combinational, zero latency,
// no flow control.
module hex_to_seg7
  import seq_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nib];

endmodule

// File: rtl/seq_scroll_display.sv
// Steps an index through the digit ROM (wrap or ping-pong, prescaled) and shows a scrolling
// N-digit window; idx, wrap and hex are all registered on the same edge, no backpressure.
module seq_scroll_display
  import seq_display_pkg::*;
#(
  parameter int N_DIGITS = 1,
  parameter int SEQ_LEN  = 5,
  parameter int TICK_DIV = 1,
  parameter int IDXW     = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  bounce,
  input  logic                  load,
  input  logic [IDXW-1:0]       load_idx,
  output logic [IDXW-1:0]       idx,
  output logic                  wrap,
  output logic [7*N_DIGITS-1:0] hex
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = IDXW + 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [IDXW-1:0] LAST      = IDXW'(SEQ_LEN - 1);
  // Reversal targets collapse to 0 for a one-entry sequence
  localparam logic [IDXW-1:0] REV_DOWN  = IDXW'((SEQ_LEN > 1) ? SEQ_LEN - 2 : 0);
  localparam logic [IDXW-1:0] REV_UP    = IDXW'((SEQ_LEN > 1) ? 1 : 0);

  logic [TW-1:0]         tick, tick_nxt;
  dir_e                  bdir, bdir_nxt;
  logic [IDXW-1:0]       idx_nxt, win_idx;
  logic                  wrap_nxt, step, at_last, at_first;
  logic [7*N_DIGITS-1:0] seg_nxt;

  always_comb begin
    step     = en && (tick == TICK_LAST);
    at_last  = (idx == LAST);
    at_first = (idx == '0);
    tick_nxt = tick;
    idx_nxt  = idx;
    bdir_nxt = bdir;
    wrap_nxt = 1'b0;
    if (load) begin
      idx_nxt  = (load_idx > LAST) ? LAST : load_idx;
      tick_nxt = '0;
    end else begin
      if (!bounce) begin
        bdir_nxt = dir ? DOWN : UP;
      end
      if (en) begin
        tick_nxt = step ? '0 : tick + TW'(1);
      end
      if (step) begin
        if (!bounce) begin
          if (!dir) begin
            idx_nxt  = at_last ? '0 : idx + IDXW'(1);
            wrap_nxt = at_last;
          end else begin
            idx_nxt  = at_first ? LAST : idx - IDXW'(1);
            wrap_nxt = at_first;
          end
        end else if (bdir == UP) begin
          if (at_last) begin
            idx_nxt  = REV_DOWN;
            bdir_nxt = DOWN;
            wrap_nxt = 1'b1;
          end else begin
            idx_nxt  = idx + IDXW'(1);
          end
        end else begin
          if (at_first) begin
            idx_nxt  = REV_UP;
            bdir_nxt = UP;
            wrap_nxt = 1'b1;
          end else begin
            idx_nxt  = idx - IDXW'(1);
          end
        end
      end
    end
  end

  // Window is decoded from the index that will be registered, so hex never lags idx
  assign win_idx = reset ? '0 : idx_nxt;

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    localparam int OFF = (N_DIGITS - 1 - k) % SEQ_LEN;
    logic [AW-1:0] sum;
    logic [AW-1:0] addr;
    assign sum  = {1'b0, win_idx} + AW'(OFF);
    assign addr = (sum >= AW'(SEQ_LEN)) ? sum - AW'(SEQ_LEN) : sum;
    hex_to_seg7 u_seg (
      .nib (SEQ_ROM[4'(addr)]),
      .seg (seg_nxt[7*k +: 7])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick <= '0;
      idx  <= '0;
      bdir <= UP;
      wrap <= 1'b0;
    end else begin
      tick <= tick_nxt;
      idx  <= idx_nxt;
      bdir <= bdir_nxt;
      wrap <= wrap_nxt;
    end
    hex <= seg_nxt;
  end

endmodule

// File: tb/tb_seq_scroll_display.sv
// Directed bench: four instances (base, 3-digit window, prescaled, single-entry) on shared stimulus.
module tb_seq_scroll_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, dir, bounce, load;
  logic [2:0] load_idx;
  logic [0:0] load_idx_s;
  logic [2:0] idx, idx_w, idx_p;
  logic [0:0] idx_s;
  logic       wrap, wrap_w, wrap_p, wrap_s;
  logic [6:0] hex, hex_p, hex_s;
  logic [20:0] hex_w;

  int n_checks = 0;
  int n_errors = 0;

  // Segment codes for the sequence 3,1,4,1,5 at idx 0..4
  logic [6:0] exp_hex [5] = '{7'b0110000, 7'b1111001, 7'b0011001, 7'b1111001, 7'b0010010};
  int fwd_idx [5] = '{1, 2, 3, 4, 0};
  int bnc_idx [6] = '{4, 3, 2, 1, 0, 1};
  int bnc_wrp [6] = '{0, 1, 0, 0, 0, 1};

  seq_scroll_display #(.N_DIGITS(1), .SEQ_LEN(5), .TICK_DIV(1)) u_dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .bounce(bounce), .load(load),
    .load_idx(load_idx), .idx(idx), .wrap(wrap), .hex(hex));

  seq_scroll_display #(.N_DIGITS(3), .SEQ_LEN(5), .TICK_DIV(1)) u_dut_w (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .bounce(bounce), .load(load),
    .load_idx(load_idx), .idx(idx_w), .wrap(wrap_w), .hex(hex_w));

  seq_scroll_display #(.N_DIGITS(1), .SEQ_LEN(5), .TICK_DIV(3)) u_dut_p (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .bounce(bounce), .load(load),
    .load_idx(load_idx), .idx(idx_p), .wrap(wrap_p), .hex(hex_p));

  seq_scroll_display #(.N_DIGITS(1), .SEQ_LEN(1), .TICK_DIV(1)) u_dut_s (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .bounce(bounce), .load(load),
    .load_idx(load_idx_s), .idx(idx_s), .wrap(wrap_s), .hex(hex_s));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] win3(input int i);
    return {exp_hex[i % 5], exp_hex[(i + 1) % 5], exp_hex[(i + 2) % 5]};
  endfunction

  initial begin
    reset = 1'b1; en = 1'b0; dir = 1'b0; bounce = 1'b0; load = 1'b0;
    load_idx = '0; load_idx_s = '0;
    cyc();
    chk("rst_idx", 32'(idx), 0);
    chk("rst_hex", 32'(hex), 32'(7'b0110000));
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_hex_w", 32'(hex_w), 32'({7'b0110000, 7'b1111001, 7'b0011001}));
    chk("rst_hex_s", 32'(hex_s), 32'(7'b0110000));

    // Forward wrap
    reset = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("fwd_idx", 32'(idx), 32'(fwd_idx[i]));
      chk("fwd_wrap", 32'(wrap), (i == 4) ? 1 : 0);
      chk("fwd_hex", 32'(hex), 32'(exp_hex[fwd_idx[i]]));
      chk("fwd_hex_w", 32'(hex_w), 32'(win3(fwd_idx[i])));
      chk("len1_idx", 32'(idx_s), 0);
      chk("len1_wrap", 32'(wrap_s), 1);
    end

    // Backward wrap
    dir = 1'b1;
    cyc();
    chk("bwd_idx", 32'(idx), 4);
    chk("bwd_hex", 32'(hex), 32'(7'b0010010));
    chk("bwd_wrap", 32'(wrap), 1);
    cyc();
    chk("bwd_idx2", 32'(idx), 3);
    chk("bwd_wrap2", 32'(wrap), 0);

    // Freeze with en low
    en = 1'b0;
    cyc();
    cyc();
    chk("frz_idx", 32'(idx), 3);

    // Mid-run reset
    en = 1'b1; reset = 1'b1;
    cyc();
    chk("rst2_idx", 32'(idx), 0);
    chk("rst2_hex", 32'(hex), 32'(7'b0110000));
    chk("rst2_wrap", 32'(wrap), 0);
    reset = 1'b0;

    // Bounce from a loaded index
    en = 1'b0; dir = 1'b0;
    cyc();
    load = 1'b1; load_idx = 3'd3;
    cyc();
    chk("ld3_idx", 32'(idx), 3);
    load = 1'b0; bounce = 1'b1; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dir = 1'($urandom_range(0, 1));
      cyc();
      chk("bnc_idx", 32'(idx), 32'(bnc_idx[i]));
      chk("bnc_wrap", 32'(wrap), 32'(bnc_wrp[i]));
    end

    // Clamped load beats step
    bounce = 1'b0; dir = 1'b0; load = 1'b1; load_idx = 3'd7; load_idx_s = 1'b1;
    cyc();
    chk("ldc_idx", 32'(idx), 4);
    chk("ldc_wrap", 32'(wrap), 0);
    chk("ldc_hex", 32'(hex), 32'(7'b0010010));
    chk("ldc_hex_w", 32'(hex_w), 32'({7'b0010010, 7'b0110000, 7'b1111001}));
    chk("ldc_idx_s", 32'(idx_s), 0);

    // Reset beats load
    load_idx = 3'd2; reset = 1'b1;
    cyc();
    chk("rstld_idx", 32'(idx), 0);
    chk("rstld_idx_p", 32'(idx_p), 0);
    reset = 1'b0; load = 1'b0; load_idx_s = 1'b0;

    // Prescaler, TICK_DIV=3
    cyc();
    chk("pre_e1", 32'(idx_p), 0);
    cyc();
    chk("pre_e2", 32'(idx_p), 0);
    cyc();
    chk("pre_e3", 32'(idx_p), 1);
    chk("pre_e3_hex", 32'(hex_p), 32'(7'b1111001));
    cyc();
    en = 1'b0;
    cyc();
    cyc();
    chk("pre_pause", 32'(idx_p), 1);
    en = 1'b1;
    cyc();
    chk("pre_e7", 32'(idx_p), 1);
    cyc();
    chk("pre_e8", 32'(idx_p), 2);
    cyc();
    load = 1'b1; load_idx = 3'd3;
    cyc();
    chk("pre_ld", 32'(idx_p), 3);
    load = 1'b0;
    cyc();
    cyc();
    chk("pre_ld_e2", 32'(idx_p), 3);
    cyc();
    chk("pre_ld_e3", 32'(idx_p), 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_scroll_display.md
# seq_scroll_display

Parametrised successor to the single-digit Lab 4 sequence state machine. It steps an index through a fixed digit sequence. Digit values come from a shared ROM. The block drives N seven-segment displays as a scrolling window onto that sequence. It adds forward/backward wrap, ping-pong (bounce) mode, a step prescaler, synchronous load, and a wrap/reversal pulse.

## Interface
- N_DIGITS, 1: number of HEX displays driven (1..6).
- SEQ_LEN, 5: sequence length (1..16); uses ROM entries 0..SEQ_LEN-1.
- TICK_DIV, 1: enabled cycles per step (≥1).
- IDXW, derived: max(1, clog2(SEQ_LEN)).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  one clock; reset is synchronous and active-high.
- en  in  1  step enable; 0 freezes index and prescaler.
- dir  in  1  0 forward (idx+1), 1 backward (idx-1); used in wrap mode only.
- bounce  in  1  0 wrap mode, 1 ping-pong mode.
- load  in  1  synchronous index load.
- load_idx  in  IDXW  value to load.
- idx  out  IDXW  current sequence index.
- wrap  out  1  one-cycle pulse after a rollover or reversal step.
- hex  out  7*N_DIGITS  active-low segments; digit k = hex[7k+6:7k], bit order {g,f,e,d,c,b,a}.

## Operation
- **Priority per edge:** reset > load > step.
- **Reset:** idx=0, tick=0, bdir=0 (up), wrap=0. hex shows the window at idx 0.
- **Load:**
  - idx = min(load_idx, SEQ_LEN-1).
  - tick=0.
  - wrap=0.
  - bdir unchanged.
- **Step condition:** en=1 and tick==TICK_DIV-1. The step sets tick=0.
- **Prescaler:** when en=1 and no step occurs, tick increments. When en=0, tick holds.
- **Wrap mode (bounce=0):**
  - Forward: idx = (idx==SEQ_LEN-1) ? 0 : idx+1.
  - Backward: idx = (idx==0) ? SEQ_LEN-1 : idx-1.
  - wrap=1 on the rollover step.
  - bdir follows dir every cycle.
- **Bounce mode (bounce=1):**
  - dir is ignored; moves follow bdir.
  - When a step would leave [0, SEQ_LEN-1], bdir flips and idx moves one the other way. Endpoints are not repeated: 0,1,..,L-1,L-2,..,0,1.
  - wrap=1 on a reversal step.
  - Entering bounce mode keeps the current bdir.
- **SEQ_LEN=1:** idx stays 0, and every step pulses wrap.
- **wrap:** registered; high for exactly the cycle after the qualifying step edge. Otherwise 0.
- **Window:** the leftmost digit (k=N_DIGITS-1) shows ROM[idx]. Digit k shows ROM[(idx + N_DIGITS-1-k) mod SEQ_LEN].
- **Segment encoding:** 0-F, standard active-low. Examples: 1=1111001, 3=0110000, 4=0011001, 5=0010010, 9=0010000.
- **Mid-run changes:** a change of dir, bounce or en takes effect at the next edge. There is no glitch on idx.

## Timing
- All state is registered on the clk rising edge.
- hex is registered from next-state idx. idx and hex change on the same edge, with zero cycles of skew between them.
- Step latency: the first step occurs on the TICK_DIV-th enabled edge after reset or load.
- Reset or load asserted mid-count discards the partial prescaler count.
- Outputs have no combinational path from inputs.

## Structure
- Package seq_display_pkg holds:
  - SEG_LUT: 16×7 active-low codes.
  - SEQ_ROM: 16×4 = 3,1,4,1,5,9,2,6,5,3,5,8,9,7,9,3.
  - Direction constants UP=0, DOWN=1.
- Sub-module hex_to_seg7: combinational nibble → 7-bit decoder, instantiated N_DIGITS times via generate.
- Top-level contents:
  - Prescaler counter.
  - Index/bdir FSM: states UP, DOWN.
  - Window address arithmetic: modulo by compare-subtract, with no divider.
  - Output registers.

## Test plan
All scenarios use N_DIGITS=1, SEQ_LEN=5 unless noted; the sequence is 3,1,4,1,5.

1. **Reset:** reset=1 for 1 edge → idx=0, hex=0110000, wrap=0. Repeating reset mid-run gives the same result.
2. **Forward wrap:** en=1, dir=0, 5 edges → idx 1,2,3,4,0. hex=0011001 after edge 2. wrap=1 only in the cycle after 4→0.
3. **Backward wrap:** from idx=0, dir=1, 1 edge → idx=4, hex=0010010, wrap=1. The next edge gives idx=3, wrap=0.
4. **Bounce:** load 3, then bounce=1 with dir toggling randomly → idx 4,3,2,1,0,1. wrap=1 after the 4→3 and 0→1 steps only.
5. **Prescaler** (TICK_DIV=3): en=1 → idx steps every 3rd edge. Dropping en for 2 cycles after tick=1 delays the step by exactly 2 edges.
6. **Load and priority:**
   - load=1, load_idx=7, en=1 → idx=4 (clamped), no step, tick=0, wrap=0.
   - load and reset in the same cycle → idx=0.
   - N_DIGITS=3 at idx=4 → hex digits (left→right) 5,3,1 = 0010010, 0110000, 1111001.
